output_accum_requester: RTL and testbench

// Initiator side of the output-memory package interface. Takes 512-bit partial-sum packages from
// the CIM datapath, reads the stored partial sum (port 1), adds lane-wise with saturation, and

---
 rtl/output_mem_pkg.sv | 19 +
 rtl/output_accum_requester_lane_sat_adder.sv | 21 ++
 rtl/output_accum_requester.sv | 163 ++++++++++++++++
 tb/tb_output_accum_requester.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_mem_pkg.sv
// Shared types and lane arithmetic for the output-memory accumulate requester.
package output_mem_pkg;

    localparam int ELEM_W = 16;
    localparam int LANES  = 512 / ELEM_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} req_state_t;

    // Signed add clamped to the lane range; overflow shows as a sign mismatch in the extra bit.
    function automatic logic [ELEM_W-1:0] sat_add(input logic [ELEM_W-1:0] a,
                                                  input logic [ELEM_W-1:0] b);
        logic [ELEM_W:0] s;
        s = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
        if (s[ELEM_W] != s[ELEM_W-1])
            return s[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
        return s[ELEM_W-1:0];
    endfunction

endpackage

// File: rtl/output_accum_requester_lane_sat_adder.sv
// Combinational lane-wise saturating adder; bypass passes operand a through unchanged.
module lane_sat_adder
    import output_mem_pkg::*;
#(
    parameter int LANES_P = LANES
) (
    input  logic [LANES_P*ELEM_W-1:0] a,
    input  logic [LANES_P*ELEM_W-1:0] b,
    input  logic                      bypass,
    output logic [LANES_P*ELEM_W-1:0] y
);

    always_comb begin
        y = a;
        if (!bypass) begin
            for (int i = 0; i < LANES_P; i++)
                y[i*ELEM_W +: ELEM_W] = sat_add(a[i*ELEM_W +: ELEM_W], b[i*ELEM_W +: ELEM_W]);
        end
    end

endmodule

// File: rtl/output_accum_requester.sv
// Read-modify-write requester: reads the stored partial sum, adds the incoming package
// lane-wise with saturation and writes the result back, one package per cycle.
module output_accum_requester
    import output_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 512,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              flush_in,
    output logic              flush_done,
    output logic              mem_rd_valid,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_resp_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_valid,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic              err,
    output req_state_t        state_dbg
);

    localparam int NLANES = DATA_W / ELEM_W;

    // Handshake: a package transfers on a clk edge where in_valid && in_ready; in_ready
    // never depends on in_valid, only on in_addr, the FSM state and the in-flight entries.
    req_state_t state;

    logic              req_v, req_first;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic [RD_LAT-1:0] pipe_v, pipe_first;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic [DATA_W-1:0] pipe_data [RD_LAT];

    logic              wr_v;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              hazard, accept, add_v, add_first, add_needs_rd;
    logic [DATA_W-1:0] rd_operand, sum;

    always_comb begin
        hazard = (req_v && req_addr == in_addr) || (wr_v && wr_addr == in_addr);
        for (int k = 0; k < RD_LAT; k++)
            if (pipe_v[k] && pipe_addr[k] == in_addr) hazard = 1'b1;
    end

    assign in_ready     = (state == IDLE || state == RUN) && !hazard;
    assign accept       = in_valid && in_ready;
    assign add_v        = pipe_v[RD_LAT-1];
    assign add_first    = pipe_first[RD_LAT-1];
    assign add_needs_rd = add_v && !add_first;
    // A missing response contributes zero so the write still goes out.
    assign rd_operand   = (add_needs_rd && mem_rd_resp_valid) ? mem_rd_data : '0;

    lane_sat_adder #(.LANES_P(NLANES)) u_lane_sat_adder (
        .a      (pipe_data[RD_LAT-1]),
        .b      (rd_operand),
        .bypass (add_first),
        .y      (sum)
    );

    assign busy         = req_v || (|pipe_v) || wr_v;
    assign mem_rd_valid = req_v && !req_first;
    assign mem_rd_addr  = req_addr;
    assign mem_wr_valid = wr_v;
    assign mem_wr_addr  = wr_addr;
    assign mem_wr_data  = wr_data;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_v      <= 1'b0;
            req_first  <= 1'b0;
            req_addr   <= '0;
            req_data   <= '0;
            pipe_v     <= '0;
            pipe_first <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_addr[k] <= '0;
                pipe_data[k] <= '0;
            end
            wr_v       <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            req_v <= accept;
            if (accept) begin
                req_first <= in_first;
                req_addr  <= in_addr;
                req_data  <= in_data;
            end
            pipe_v[0]     <= req_v;
            pipe_first[0] <= req_first;
            pipe_addr[0]  <= req_addr;
            pipe_data[0]  <= req_data;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k]     <= pipe_v[k-1];
                pipe_first[k] <= pipe_first[k-1];
                pipe_addr[k]  <= pipe_addr[k-1];
                pipe_data[k]  <= pipe_data[k-1];
            end
            wr_v <= add_v;
            if (add_v) begin
                wr_addr <= pipe_addr[RD_LAT-1];
                wr_data <= sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((add_needs_rd && !mem_rd_resp_valid) ||
                     (mem_rd_resp_valid && !add_needs_rd)) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_in) begin
                        if (busy || accept) begin
                            state <= DRAIN;
                        end else begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end
                    end else if (in_valid) begin
                        state <= RUN;
                    end
                end
                RUN: if (flush_in) state <= DRAIN;
                DRAIN: begin
                    // Nothing new enters while draining, so empty stage registers mean done.
                    if (!busy) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_accum_requester.sv
// Self-checking bench: a memory responder serves reads and scores writes against an expected queue.
module tb_output_accum_requester;
    import output_mem_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 512;
    localparam int RD_LAT = 1;
    localparam int NL     = DATA_W / ELEM_W;

    typedef logic [DATA_W-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0, in_first = 1'b0, flush_in = 1'b0;
    logic              in_ready, flush_done;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              mem_rd_valid, mem_rd_resp_valid = 1'b0;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [DATA_W-1:0] mem_rd_data = '0, mem_wr_data;
    logic              mem_wr_valid, busy, err;
    req_state_t        state_dbg;

    output_accum_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_first(in_first), .flush_in(flush_in), .flush_done(flush_done),
        .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr),
        .mem_rd_resp_valid(mem_rd_resp_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int    n_tests = 0, n_fail = 0;
    word_t mem [256];
    word_t model [256];
    logic  [DATA_W-1:0] exp_q[$];
    logic  [ADDR_W-1:0] exp_addr_q[$];
    int    exp_cyc_q[$];
    logic  [ADDR_W-1:0] rd_addr_q[$];
    int    rd_cyc_q[$];
    logic  withhold = 1'b0;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t fill(input int v);
        word_t r;
        for (int i = 0; i < NL; i++) r[i*ELEM_W +: ELEM_W] = 16'(v);
        return r;
    endfunction

    function automatic word_t acc_model(input word_t s, input word_t d);
        word_t r;
        int    v;
        for (int i = 0; i < NL; i++) begin
            v = int'($signed(s[i*ELEM_W +: ELEM_W])) + int'($signed(d[i*ELEM_W +: ELEM_W]));
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            r[i*ELEM_W +: ELEM_W] = 16'(v);
        end
        return r;
    endfunction

    function automatic word_t rand_word();
        word_t r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Memory responder: answers reads RD_LAT cycles later and scores every write.
    initial begin
        logic              rd_pend;
        logic [ADDR_W-1:0] rd_a;
        forever begin
            @(negedge clk);
            rd_pend = mem_rd_valid;
            rd_a    = mem_rd_addr;
            if (mem_rd_valid) begin
                if (rd_addr_q.size() == 0) begin
                    check("rd_unexpected", word_t'(mem_rd_valid), word_t'(1'b0));
                end else begin
                    check("rd_addr", word_t'(mem_rd_addr), word_t'(rd_addr_q.pop_front()));
                    check("rd_cycle", word_t'(cyc), word_t'(rd_cyc_q.pop_front()));
                end
            end
            if (mem_wr_valid) begin
                mem[mem_wr_addr] = mem_wr_data;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", word_t'(mem_wr_valid), word_t'(1'b0));
                end else begin
                    check("wr_addr", word_t'(mem_wr_addr), word_t'(exp_addr_q.pop_front()));
                    check("wr_data", mem_wr_data, exp_q.pop_front());
                    check("wr_cycle", word_t'(cyc), word_t'(exp_cyc_q.pop_front()));
                end
            end
            @(posedge clk);
            #1;
            mem_rd_resp_valid = rd_pend && !withhold && rst_n;
            mem_rd_data       = rd_pend ? mem[rd_a] : '0;
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [ADDR_W-1:0] a, input word_t d, input logic f,
                        output int acc_cyc);
        word_t e;
        int    n;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_first = f;
        n        = 0;
        acc_cyc  = -1;
        while (acc_cyc < 0 && n < 40) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                e = f ? d : acc_model(withhold ? '0 : model[a], d);
                model[a] = e;
                exp_q.push_back(e);
                exp_addr_q.push_back(a);
                exp_cyc_q.push_back(cyc + 2 + RD_LAT);
                if (!f) begin
                    rd_addr_q.push_back(a);
                    rd_cyc_q.push_back(cyc + 1);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
        check("accepted", word_t'(acc_cyc >= 0), word_t'(1'b1));
    endtask

    task automatic clear_expect();
        exp_q.delete();
        exp_addr_q.delete();
        exp_cyc_q.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int    c, c1, c2, prev, done_cyc;
        word_t s, d;
        logic  fr;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = '0;
            model[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", word_t'(in_ready), word_t'(1'b1));
        check("rst_rd_valid", word_t'(mem_rd_valid), word_t'(1'b0));
        check("rst_wr_valid", word_t'(mem_wr_valid), word_t'(1'b0));
        check("rst_busy", word_t'(busy), word_t'(1'b0));
        check("rst_err", word_t'(err), word_t'(1'b0));
        check("rst_flush_done", word_t'(flush_done), word_t'(1'b0));
        check("rst_state", word_t'(state_dbg), word_t'(IDLE));
        @(posedge clk);
        #1;

        // Reset in the middle of a run with two packages in flight.
        send(8'd40, fill(1), 1'b1, c);
        send(8'd41, fill(2), 1'b1, c);
        check("busy_inflight", word_t'(busy), word_t'(1'b1));
        rst_n = 1'b0;
        clear_expect();
        #1;
        check("midrst_busy", word_t'(busy), word_t'(1'b0));
        check("midrst_wr_valid", word_t'(mem_wr_valid), word_t'(1'b0));
        check("midrst_rd_valid", word_t'(mem_rd_valid), word_t'(1'b0));
        check("midrst_wr_data", mem_wr_data, '0);
        check("midrst_in_ready", word_t'(in_ready), word_t'(1'b1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_no_wr", word_t'(mem_wr_valid), word_t'(1'b0));
        end
        @(posedge clk);
        #1;

        // First-pass package: direct write, no read.
        send(8'd5, fill(3), 1'b1, c);
        // Accumulate onto stored 100.
        mem[9] = fill(100);
        model[9] = fill(100);
        send(8'd9, fill(20), 1'b0, c);
        // Saturation corner lanes in one package.
        s = '0;
        d = '0;
        s[0 +: 16] = 16'd1;       d[0 +: 16] = 16'h7fff;
        s[16 +: 16] = 16'h8000;   d[16 +: 16] = 16'hffff;
        s[32 +: 16] = 16'd3;      d[32 +: 16] = 16'hfffb;
        mem[12] = s;
        model[12] = s;
        send(8'd12, d, 1'b0, c);
        // Same address back to back: second waits until the first write.
        mem[7] = fill(1);
        model[7] = fill(1);
        send(8'd7, fill(10), 1'b0, c1);
        send(8'd7, fill(4), 1'b0, c2);
        check("hazard_gap", word_t'(c2 - c1), word_t'(3 + RD_LAT));

        // Random packages to distinct addresses stream at one per cycle.
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            mem[100+i]   = rand_word();
            model[100+i] = mem[100+i];
            fr = 1'($urandom_range(0, 1));
            send(8'(100 + i), rand_word(), fr, c);
            if (i > 0) check("stream_rate", word_t'(c - prev), word_t'(1));
            prev = c;
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mem5_lane", word_t'(mem[5][15:0]), word_t'(16'd3));
        check("mem9_lane", word_t'(mem[9][15:0]), word_t'(16'd120));
        check("mem7_final", word_t'(mem[7][NL*ELEM_W-1 -: 16]), word_t'(16'd15));
        check("sat_pos", word_t'(mem[12][15:0]), word_t'(16'h7fff));
        check("sat_neg", word_t'(mem[12][31:16]), word_t'(16'h8000));
        check("sat_mid", word_t'(mem[12][47:32]), word_t'(16'hfffe));
        check("err_clean", word_t'(err), word_t'(1'b0));
        @(posedge clk);
        #1;

        // Withheld read response raises sticky err.
        withhold = 1'b1;
        mem[20] = fill(50);
        model[20] = fill(50);
        send(8'd20, fill(-7), 1'b0, c);
        repeat (5) @(posedge clk);
        #1;
        check("err_set", word_t'(err), word_t'(1'b1));
        withhold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", word_t'(err), word_t'(1'b1));

        // Flush together with an accepted package, then drain.
        flush_in = 1'b1;
        send(8'd21, fill(1), 1'b1, c);
        flush_in = 1'b0;
        @(negedge clk);
        check("drain_state", word_t'(state_dbg), word_t'(DRAIN));
        check("drain_in_ready", word_t'(in_ready), word_t'(1'b0));
        done_cyc = -1;
        for (int i = 0; i < 20 && done_cyc < 0; i++) begin
            if (flush_done) done_cyc = cyc;
            else @(negedge clk);
        end
        check("flush_done_cycle", word_t'(done_cyc), word_t'(c + 4 + RD_LAT));
        @(negedge clk);
        check("flush_done_pulse", word_t'(flush_done), word_t'(1'b0));
        check("after_done_state", word_t'(state_dbg), word_t'(IDLE));

        // Flush while idle and empty completes on the next cycle.
        @(posedge clk);
        #1;
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        @(negedge clk);
        check("idle_flush_done", word_t'(flush_done), word_t'(1'b1));
        @(negedge clk);
        check("idle_flush_pulse", word_t'(flush_done), word_t'(1'b0));

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("exp_q_drained", word_t'(exp_q.size()), word_t'(0));
        check("rd_q_drained", word_t'(rd_addr_q.size()), word_t'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
